// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the LEGv8 datapath.
// MUL/UMULH use a shift-add over a 2*WIDTH accumulator (LSB first).
// UDIV/SDIV use restoring division (MSB first). SDIV divides magnitudes
// and fixes the quotient sign when the result is written back.
// Handshake: start is sampled only in IDLE; busy is high from the cycle
// after accept until the unit is back in IDLE; write_en pulses for exactly
// one cycle (DONE) with write_data/write_add stable from the posedge.
module mul_div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_add,
  output logic             busy,
  output logic             write_en,
  output logic [4:0]       write_add,
  output logic [WIDTH-1:0] write_data,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic wen_q, wen_d;
  logic load, iterate, finish;

  // Operation context and datapath registers.
  logic [1:0]         op_q, op_d;
  logic [4:0]         dest_q, dest_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or quotient in low half
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;

  // Per-iteration datapath terms.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ok;
  logic [WIDTH:0]     div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   result;

  assign busy        = busy_q;
  assign write_en    = wen_q;
  assign write_add   = dest_q;
  assign write_data  = wdata_q;
  assign dbg_state_o = state_q;

  // FSM next-state, iteration counter and registered status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = CNT_INIT;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        iterate = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    wen_d  = (state_d == S_DONE);
  end

  // FSM state register with synchronous reset (aborts any operation).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
    end
  end

  // Shift-add and restoring-divide step, operand capture and result select.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift    = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_trial    = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ok       = ~div_trial[WIDTH+1];
    div_rem_next = div_ok ? div_trial[WIDTH:0] : div_shift;
    div_quo_next = {acc_q[WIDTH-2:0], div_ok};

    a_abs = (op == OP_SDIV && operand_a[WIDTH-1]) ? (~operand_a + W_ONE) : operand_a;
    b_abs = (op == OP_SDIV && operand_b[WIDTH-1]) ? (~operand_b + W_ONE) : operand_b;

    case (op_q)
      OP_MUL:   result = mul_next[WIDTH-1:0];
      OP_UMULH: result = mul_next[2*WIDTH-1:WIDTH];
      OP_UDIV:  result = div0_q ? '0 : div_quo_next;
      default:  result = div0_q ? '0 : (neg_q ? (~div_quo_next + W_ONE) : div_quo_next);
    endcase

    op_d    = op_q;
    dest_d  = dest_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;

    if (load) begin
      op_d   = op;
      dest_d = dest_add;
      neg_d  = (op == OP_SDIV) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      div0_d = (operand_b == '0);
      rem_d  = '0;
      if (op[1]) begin
        opnd_d = b_abs;
        acc_d  = {{WIDTH{1'b0}}, a_abs};
      end else begin
        opnd_d = operand_a;
        acc_d  = {{WIDTH{1'b0}}, operand_b};
      end
    end

    if (iterate) begin
      if (op_q[1]) begin
        acc_d = {{WIDTH{1'b0}}, div_quo_next};
        rem_d = div_rem_next;
      end else begin
        acc_d = mul_next;
      end
    end

    if (finish) begin
      wdata_d = result;
    end
  end

  // Datapath registers; write_data holds until the next DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= 2'b00;
      dest_q  <= 5'd0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
    end else begin
      op_q    <= op_d;
      dest_q  <= dest_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vectors, expected queue, negedge monitor.
module tb_mul_div_unit;

  localparam int W = 64;
  localparam int LAT = W + 1;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [4:0]   dest_add;
  logic         busy;
  logic         write_en;
  logic [4:0]   write_add;
  logic [W-1:0] write_data;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_add_q[$];

  int checks = 0;
  int errors = 0;
  bit abort_flag = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dest_add   (dest_add),
    .busy       (busy),
    .write_en   (write_en),
    .write_add  (write_add),
    .write_data (write_data),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
    end
  endtask

  // Driver: one-cycle start pulse; inputs scrambled afterwards so any
  // re-sampling of the operands would corrupt the result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] d, input logic [W-1:0] exp);
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_add = d;
    exp_q.push_back(exp);
    exp_add_q.push_back(d);
    @(negedge clock);
    start = 1'b0;
    operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
    op = 2'($urandom_range(0, 3));
    dest_add = 5'($urandom_range(0, 31));
    check("busy_after_accept", W'(busy), W'(1));
    check("state_run_after_accept", W'(dbg_state), W'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * LAT; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", busy, 3 * LAT);
    end
  endtask

  // Monitor: pops expectations on each write_en, checks pulse width,
  // write position inside the busy window, and busy window length.
  int  busy_cnt = 0;
  bit  prev_busy = 0;
  bit  prev_wen = 0;
  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (write_en) begin
      check("write_en_single_cycle", W'(prev_wen), W'(0));
      check("write_en_position", W'(busy_cnt), W'(LAT));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: write_en=1 data=0x%016h, expected no write", write_data);
      end else begin
        check("write_data", write_data, exp_q.pop_front());
        check("write_add", W'(write_add), W'(exp_add_q.pop_front()));
      end
    end
    if (!busy && prev_busy) begin
      if (!abort_flag) check("busy_length", W'(busy_cnt), W'(LAT));
      busy_cnt = 0;
    end
    if (!busy) busy_cnt = 0;
    prev_busy = busy;
    prev_wen  = write_en;
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; dest_add = 5'd0;
    repeat (3) @(negedge clock);
    // Start during reset must lose to reset.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("reset_busy", W'(busy), W'(0));
    check("reset_write_en", W'(write_en), W'(0));
    check("reset_write_data", write_data, '0);
    check("reset_write_add", W'(write_add), W'(0));
    check("reset_state", W'(dbg_state), W'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_no_start_busy", W'(busy), W'(0));

    // Multiply.
    issue(2'b00, 64'd7, 64'd6, 5'd5, 64'd42);
    wait_idle();
    issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'd1);
    wait_idle();
    issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_idle();
    issue(2'b01, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd31, 64'd1);
    wait_idle();
    issue(2'b00, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd31, 64'd0);
    wait_idle();
    issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_idle();

    // Signed divide.
    issue(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_idle();
    issue(2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h8000_0000_0000_0000);
    wait_idle();
    issue(2'b11, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_idle();
    issue(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 5'd14, 64'd3);
    wait_idle();
    issue(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd15, 64'd0);
    wait_idle();

    // Unsigned divide.
    issue(2'b10, 64'd100, 64'd7, 5'd10, 64'd14);
    wait_idle();
    issue(2'b10, 64'd100, 64'd0, 5'd11, 64'd0);
    wait_idle();
    issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    issue(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'd0);
    wait_idle();

    // Start while busy: busy cycle 1 is the negedge issue() returns on.
    issue(2'b10, 64'd100, 64'd7, 5'd3, 64'd14);
    repeat (9) @(negedge clock);
    start = 1'b1; op = 2'b00; operand_a = 64'd11; operand_b = 64'd13; dest_add = 5'd20;
    @(negedge clock);
    start = 1'b0;
    repeat (53) @(negedge clock);
    start = 1'b1; op = 2'b01; operand_a = 64'd5; operand_b = 64'd9; dest_add = 5'd21;
    repeat (2) @(negedge clock);
    start = 1'b0;
    check("no_accept_from_done", W'(busy), W'(0));
    repeat (3) @(negedge clock);
    check("still_idle_after_ignored_start", W'(busy), W'(0));

    // Reset mid-run at busy cycle 30.
    issue(2'b00, 64'd123, 64'd456, 5'd4, 64'd56088);
    repeat (28) @(negedge clock);
    abort_flag = 1'b1;
    exp_q.delete();
    exp_add_q.delete();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", W'(busy), W'(0));
    check("abort_write_en", W'(write_en), W'(0));
    check("abort_write_data", write_data, '0);
    check("abort_state", W'(dbg_state), W'(0));
    repeat (LAT + 10) @(negedge clock);
    abort_flag = 1'b0;
    issue(2'b00, 64'd3, 64'd3, 5'd2, 64'd9);
    wait_idle();

    repeat (5) @(negedge clock);
    check("pending_expectations", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
